// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the register scoreboard.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
package hazard_pkg;

  // Register 0 is hardwired and never tracked.
  localparam int REG_ZERO = 0;

  // Default latency field width and the matching reservation vector width.
  localparam int LAT_WIDTH_DEF  = 4;
  localparam int RESV_WIDTH_DEF = 1 << LAT_WIDTH_DEF;

  // Writeback reservation vector width: one slot per representable latency.
  function automatic int unsigned resv_width(input int unsigned lat_width);
    return 32'd1 << lat_width;
  endfunction

  // Effective latency: without forwarding the consumer must also wait for
  // writeback, so the distance is added; saturated to the field maximum.
  function automatic int unsigned eff_latency(input int unsigned lat,
                                              input int unsigned forwarding,
                                              input int unsigned wb_distance,
                                              input int unsigned lat_width);
    int unsigned e;
    int unsigned lat_max;
    lat_max = (32'd1 << lat_width) - 32'd1;
    e = lat + ((forwarding != 0) ? 32'd0 : wb_distance);
    return (e > lat_max) ? lat_max : e;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/memory-completion bundle between the pipeline and the scoreboard.
// Latency: n/a (wires only).
// Backpressure: stall is the only backpressure, driven by the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LAT_WIDTH      = 4
);
  logic                      dec_valid;
  logic [REG_ADDR_WIDTH-1:0] dec_rs1;
  logic                      dec_rs1_used;
  logic [REG_ADDR_WIDTH-1:0] dec_rs2;
  logic                      dec_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;
  logic                      dec_rd_write;
  logic                      dec_is_load;
  logic [LAT_WIDTH-1:0]      dec_latency;
  logic                      mem_done;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      stall;
  logic [NUM_REGS-1:0]       busy_vec;
  logic [31:0]               stall_cycles;

  // Pipeline side: presents decode and load completions, observes stall.
  modport master (
    output dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           dec_rd, dec_rd_write, dec_is_load, dec_latency, mem_done, mem_rd,
    input  stall, busy_vec, stall_cycles
  );

  // Scoreboard side.
  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           dec_rd, dec_rd_write, dec_is_load, dec_latency, mem_done, mem_rd,
    output stall, busy_vec, stall_cycles
  );
endinterface

// File: rtl/hazard_entry.sv
// Per-register pending-write state: busy flag, load-wait flag, countdown.
// Latency: set/clear take effect at the next edge; ready is combinational.
// Backpressure: none; the top guarantees set and mem_clr never collide.
module hazard_entry #(
  parameter int LAT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set,
  input  logic                 set_load,
  input  logic [LAT_WIDTH-1:0] set_cnt,
  input  logic                 mem_clr,
  output logic                 busy,
  output logic                 wait_mem,
  output logic                 ready
);

  logic [LAT_WIDTH-1:0] cnt;

  // Create on issue, otherwise count down and retire at 1->0 or on load completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      wait_mem <= 1'b0;
      cnt      <= '0;
    end else if (set || set_load) begin
      busy     <= 1'b1;
      wait_mem <= set_load;
      cnt      <= set ? set_cnt : '0;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - LAT_WIDTH'(1);
      end
      if (cnt == LAT_WIDTH'(1)) begin
        busy <= 1'b0;
      end
      if (mem_clr && wait_mem) begin
        busy     <= 1'b0;
        wait_mem <= 1'b0;
      end
    end
  end

  // Last cycle of the countdown: the value is on the bypass this cycle.
  assign ready = busy && !wait_mem && (cnt == LAT_WIDTH'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard/hazard unit: RAW, WAW and writeback-port hazards hold decode.
// Latency: stall is combinational; tracking state updates at the next edge.
// Backpressure: stall=1 holds decode; no instruction is accepted while stalled.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LAT_WIDTH      = 4,
  parameter int FORWARDING     = 1,
  parameter int WB_DISTANCE    = 3
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int RESV_W = resv_width(LAT_WIDTH);

  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  wait_q;
  logic [NUM_REGS-1:0]  ready_q;
  logic [NUM_REGS-1:0]  set_vec;
  logic [NUM_REGS-1:0]  set_load_vec;
  logic [NUM_REGS-1:0]  mem_clr_vec;
  logic [RESV_W-1:0]    resv_q;
  logic [31:0]          stall_cnt;
  logic [LAT_WIDTH-1:0] eff_lat;
  logic                 rs1_nz;
  logic                 rs2_nz;
  logic                 rd_nz;
  logic                 stall;
  logic                 issue;
  logic                 issue_timed;

  assign eff_lat = LAT_WIDTH'(eff_latency(32'(bus.dec_latency), FORWARDING,
                                          WB_DISTANCE, LAT_WIDTH));

  assign rs1_nz = (bus.dec_rs1 != REG_ADDR_WIDTH'(REG_ZERO));
  assign rs2_nz = (bus.dec_rs2 != REG_ADDR_WIDTH'(REG_ZERO));
  assign rd_nz  = (bus.dec_rd  != REG_ADDR_WIDTH'(REG_ZERO));

  // Hazard detection from registered state and the decode-stage instruction.
  // A producer in its ready cycle is bypassed, so RAW ignores it; WAW does not.
  always_comb begin
    stall = 1'b0;
    if (bus.dec_valid) begin
      if (bus.dec_rs1_used && rs1_nz && busy_q[bus.dec_rs1] && !ready_q[bus.dec_rs1]) begin
        stall = 1'b1;
      end
      if (bus.dec_rs2_used && rs2_nz && busy_q[bus.dec_rs2] && !ready_q[bus.dec_rs2]) begin
        stall = 1'b1;
      end
      if (bus.dec_rd_write && rd_nz && busy_q[bus.dec_rd]) begin
        stall = 1'b1;
      end
      if (bus.dec_rd_write && rd_nz && !bus.dec_is_load &&
          (eff_lat != '0) && resv_q[eff_lat]) begin
        stall = 1'b1;
      end
    end
  end

  assign issue       = bus.dec_valid && !stall && bus.dec_rd_write && rd_nz;
  assign issue_timed = issue && !bus.dec_is_load && (eff_lat != '0);

  assign busy_q[0]       = 1'b0;
  assign wait_q[0]       = 1'b0;
  assign ready_q[0]      = 1'b0;
  assign set_vec[0]      = 1'b0;
  assign set_load_vec[0] = 1'b0;
  assign mem_clr_vec[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    assign set_vec[i]      = issue_timed && (bus.dec_rd == REG_ADDR_WIDTH'(i));
    assign set_load_vec[i] = issue && bus.dec_is_load && (bus.dec_rd == REG_ADDR_WIDTH'(i));
    assign mem_clr_vec[i]  = bus.mem_done && (bus.mem_rd == REG_ADDR_WIDTH'(i));

    hazard_entry #(.LAT_WIDTH(LAT_WIDTH)) u_entry (
      .clk      (clk),
      .reset    (reset),
      .set      (set_vec[i]),
      .set_load (set_load_vec[i]),
      .set_cnt  (eff_lat),
      .mem_clr  (mem_clr_vec[i]),
      .busy     (busy_q[i]),
      .wait_mem (wait_q[i]),
      .ready    (ready_q[i])
    );
  end

  // Writeback reservations: set and shift in the same edge, so bit k seen in
  // decode means the port is taken k cycles from now, matching a new E=k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resv_q <= '0;
    end else if (issue_timed) begin
      resv_q <= (resv_q | (RESV_W'(1) << eff_lat)) >> 1;
    end else begin
      resv_q <= resv_q >> 1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall        = stall;
  assign bus.busy_vec     = busy_q;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (forwarding and no-forwarding builds).
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: decode inputs are simply re-presented while stall is high.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic        dec_rs1_used;
  logic [4:0]  dec_rs2;
  logic        dec_rs2_used;
  logic [4:0]  dec_rd;
  logic        dec_rd_write;
  logic        dec_is_load;
  logic [3:0]  dec_latency;
  logic        mem_done;
  logic [4:0]  mem_rd;

  int checks;
  int failures;

  hazard_scoreboard_if #(.NUM_REGS(32), .REG_ADDR_WIDTH(5), .LAT_WIDTH(4)) bus0 ();
  hazard_scoreboard_if #(.NUM_REGS(32), .REG_ADDR_WIDTH(5), .LAT_WIDTH(4)) bus1 ();

  assign bus0.dec_valid = dec_valid;       assign bus1.dec_valid = dec_valid;
  assign bus0.dec_rs1 = dec_rs1;           assign bus1.dec_rs1 = dec_rs1;
  assign bus0.dec_rs1_used = dec_rs1_used; assign bus1.dec_rs1_used = dec_rs1_used;
  assign bus0.dec_rs2 = dec_rs2;           assign bus1.dec_rs2 = dec_rs2;
  assign bus0.dec_rs2_used = dec_rs2_used; assign bus1.dec_rs2_used = dec_rs2_used;
  assign bus0.dec_rd = dec_rd;             assign bus1.dec_rd = dec_rd;
  assign bus0.dec_rd_write = dec_rd_write; assign bus1.dec_rd_write = dec_rd_write;
  assign bus0.dec_is_load = dec_is_load;   assign bus1.dec_is_load = dec_is_load;
  assign bus0.dec_latency = dec_latency;   assign bus1.dec_latency = dec_latency;
  assign bus0.mem_done = mem_done;         assign bus1.mem_done = mem_done;
  assign bus0.mem_rd = mem_rd;             assign bus1.mem_rd = mem_rd;

  hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_WIDTH(5), .LAT_WIDTH(4),
                      .FORWARDING(0), .WB_DISTANCE(3)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_WIDTH(5), .LAT_WIDTH(4),
                      .FORWARDING(1), .WB_DISTANCE(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        w;
    logic        ld;
    logic [3:0]  lat;
    logic        md;
    logic [4:0]  mrd;
    logic        exp_stall;
    logic [31:0] exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic w, input logic ld, input logic [3:0] lat,
                              input logic md, input logic [4:0] mrd,
                              input logic es, input logic [31:0] eb);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.w = w; v.ld = ld; v.lat = lat; v.md = md; v.mrd = mrd;
    v.exp_stall = es; v.exp_busy = eb;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    dec_valid = v.vld; dec_rs1 = v.rs1; dec_rs1_used = v.u1;
    dec_rs2 = v.rs2; dec_rs2_used = v.u2; dec_rd = v.rd;
    dec_rd_write = v.w; dec_is_load = v.ld; dec_latency = v.lat;
    mem_done = v.md; mem_rd = v.mrd;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  vec_t tbl[15];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    idle();
    tick();
    tick();

    // Reset state.
    @(negedge clk);
    chk("rst_busy", bus1.busy_vec, 32'h0);
    chk("rst_stall", 32'(bus1.stall), 32'h0);
    chk("rst_cnt", bus1.stall_cycles, 32'h0);
    reset = 1'b1;
    tick();

    // Table: forwarding build, one row per cycle starting from empty state.
    //            vld rs1 u1 rs2 u2 rd  w ld lat md mrd  stall busy
    tbl[0]  = mk(1,  1, 1,  1, 1,  2, 1, 0, 3, 0, 0,  0, 32'h0);
    tbl[1]  = mk(1,  2, 1,  2, 1,  3, 1, 0, 1, 0, 0,  1, 32'h4);
    tbl[2]  = mk(1,  2, 1,  2, 1,  3, 1, 0, 1, 0, 0,  1, 32'h4);
    tbl[3]  = mk(1,  2, 1,  2, 1,  3, 1, 0, 1, 0, 0,  0, 32'h4);
    tbl[4]  = mk(1,  3, 1,  0, 0,  4, 1, 1, 0, 0, 0,  0, 32'h8);
    tbl[5]  = mk(1,  4, 1,  4, 1,  5, 1, 0, 2, 1, 4,  1, 32'h10);
    tbl[6]  = mk(1,  4, 1,  4, 1,  5, 1, 0, 2, 1, 9,  0, 32'h0);
    tbl[7]  = mk(1,  0, 0,  0, 0,  5, 1, 0, 1, 0, 0,  1, 32'h20);
    tbl[8]  = mk(1,  0, 0,  0, 0,  5, 1, 0, 1, 0, 0,  1, 32'h20);
    tbl[9]  = mk(1,  0, 0,  0, 0,  5, 1, 0, 1, 0, 0,  0, 32'h0);
    tbl[10] = mk(0,  5, 1,  0, 0,  0, 0, 0, 0, 0, 0,  0, 32'h20);
    tbl[11] = mk(1,  0, 1,  0, 1,  0, 1, 0, 1, 0, 0,  0, 32'h0);
    tbl[12] = mk(1,  0, 1,  0, 1,  0, 1, 0, 1, 0, 0,  0, 32'h0);
    tbl[13] = mk(1,  0, 0,  0, 1,  6, 1, 0, 0, 0, 0,  0, 32'h0);
    tbl[14] = mk(1,  6, 1,  0, 0,  0, 0, 0, 0, 0, 0,  0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), 32'(bus1.stall), 32'(tbl[i].exp_stall));
      chk($sformatf("tbl%0d_busy", i), bus1.busy_vec, tbl[i].exp_busy);
      tick();
    end

    // No forwarding: lat-1 producer needs 4 cycles, consumer stalls 3.
    do_reset();
    apply(mk(1, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("nofwd_prod_stall", 32'(bus0.stall), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(mk(1, 2, 1, 2, 1, 3, 1, 0, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk($sformatf("nofwd_c%0d", i), 32'(bus0.stall), (i < 3) ? 32'h1 : 32'h0);
      if (i == 0) chk("fwd_b2b", 32'(bus1.stall), 32'h0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("nofwd_busy", bus0.busy_vec, 32'h8);
    chk("nofwd_cnt", bus0.stall_cycles, 32'd3);
    tick();

    // Load miss: consumer waits until the edge after mem_done.
    do_reset();
    apply(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("ld_issue", 32'(bus1.stall), 32'h0);
    tick();
    for (int i = 1; i <= 9; i++) begin
      apply(mk(1, 4, 1, 4, 1, 5, 1, 0, 1, (i == 8), 4, 0, 0));
      @(negedge clk);
      chk($sformatf("ld_c%0d", i), 32'(bus1.stall), (i <= 8) ? 32'h1 : 32'h0);
      if (i == 9) chk("ld_stall_cycles", bus1.stall_cycles, 32'd8);
      tick();
    end

    // WAW against a pending load.
    apply(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0));
    tick();
    apply(mk(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("waw_stall", 32'(bus1.stall), 32'h1);
    tick();
    apply(mk(1, 0, 0, 0, 0, 8, 1, 0, 1, 1, 8, 0, 0));
    @(negedge clk);
    chk("waw_md_stall", 32'(bus1.stall), 32'h1);
    tick();
    apply(mk(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("waw_release", 32'(bus1.stall), 32'h0);
    tick();

    // Structural: lat 3 to r6 then lat 2 to r7 collide on the writeback port.
    do_reset();
    apply(mk(1, 1, 1, 1, 1, 6, 1, 0, 3, 0, 0, 0, 0));
    @(negedge clk);
    chk("st_first", 32'(bus1.stall), 32'h0);
    tick();
    apply(mk(1, 1, 1, 1, 1, 7, 1, 0, 2, 0, 0, 0, 0));
    @(negedge clk);
    chk("st_conflict", 32'(bus1.stall), 32'h1);
    tick();
    @(negedge clk);
    chk("st_issue", 32'(bus1.stall), 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("st_busy_a", bus1.busy_vec, 32'hC0);
    tick();
    @(negedge clk);
    chk("st_busy_b", bus1.busy_vec, 32'h80);
    tick();
    @(negedge clk);
    chk("st_busy_c", bus1.busy_vec, 32'h0);
    tick();

    // Asynchronous reset with three loads outstanding.
    do_reset();
    for (int r = 2; r <= 4; r++) begin
      apply(mk(1, 0, 0, 0, 0, 5'(r), 1, 1, 0, 0, 0, 0, 0));
      tick();
    end
    apply(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mr_busy_pre", bus1.busy_vec, 32'h1C);
    chk("mr_stall_pre", 32'(bus1.stall), 32'h1);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_busy", bus1.busy_vec, 32'h0);
    chk("mr_stall", 32'(bus1.stall), 32'h0);
    chk("mr_cnt", bus1.stall_cycles, 32'h0);
    tick();
    reset = 1'b1;
    apply(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    @(negedge clk);
    chk("mr_after_stall", 32'(bus1.stall), 32'h0);
    tick();
    apply(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mr_after_busy", bus1.busy_vec, 32'h0);
    tick();

    // Saturation of the stall counter.
    do_reset();
    apply(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
    tick();
    apply(mk(1, 4, 1, 4, 1, 5, 1, 0, 1, 0, 0, 0, 0));
    tick();
    force dut1.stall_cnt = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut1.stall_cnt;
    tick();
    @(negedge clk);
    chk("sat_fe", bus1.stall_cycles, 32'hFFFF_FFFE);
    tick();
    @(negedge clk);
    chk("sat_ff", bus1.stall_cycles, 32'hFFFF_FFFF);
    tick();
    tick();
    @(negedge clk);
    chk("sat_hold", bus1.stall_cycles, 32'hFFFF_FFFF);
    chk("sat_stall", 32'(bus1.stall), 32'h1);
    tick();
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
